// File: rtl/lock_manager_if.sv
// rtl/lock_manager_if.sv - command and ACK stream bundle between accelerators and the lock manager
interface lock_manager_if #(
   parameter int ACC_ID_BITS = 8
);
   logic [63:0]            in_tdata;
   logic                   in_tvalid;
   logic                   in_tready;
   logic [ACC_ID_BITS-1:0] in_tid;
   logic                   in_tlast;

   logic [63:0]            out_tdata;
   logic                   out_tvalid;
   logic                   out_tready;
   logic [ACC_ID_BITS-1:0] out_tdest;
   logic [4:0]             out_tid;

   modport master (
      output in_tdata, in_tvalid, in_tid, in_tlast, out_tready,
      input  in_tready, out_tdata, out_tvalid, out_tdest, out_tid
   );

   modport slave (
      input  in_tdata, in_tvalid, in_tid, in_tlast, out_tready,
      output in_tready, out_tdata, out_tvalid, out_tdest, out_tid
   );
endinterface

// File: rtl/lock_manager.sv
// rtl/lock_manager.sv - hardware lock arbiter (HWR_LOCK_ID 5'h15) for accelerator LOCK/UNLOCK commands
module lock_manager #(
   parameter int ACC_ID_BITS  = 8,
   parameter int NUM_LOCKS    = 16,
   parameter int LOCK_ID_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   lock_manager_if.slave        bus,
   output logic [NUM_LOCKS-1:0] locks_held,
   output logic [1:0]           err_sticky,
   input  logic                 err_clear
);
   localparam int          IDX_BITS    = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
   localparam logic [7:0]  CMD_LOCK    = 8'h04;
   localparam logic [7:0]  CMD_UNLOCK  = 8'h06;
   localparam logic [63:0] ACK_OK      = 64'h01;
   localparam logic [63:0] ACK_REJECT  = 64'h00;
   localparam logic [4:0]  HWR_LOCK_ID = 5'h15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_ACK
   } state_t;

   state_t                 state;
   logic                   is_lock_q;
   logic [ACC_ID_BITS-1:0] owner [NUM_LOCKS];

   logic [7:0]              code;
   logic [LOCK_ID_BITS-1:0] lock_id;
   logic [IDX_BITS-1:0]     idx;
   logic                    id_ok;
   logic                    cmd_lock;
   logic                    cmd_unlock;
   logic                    hs_idle;
   logic                    hs_drain_last;
   logic                    grant;
   logic                    release_ok;
   logic [1:0]              err_set;
   logic                    unused_bits;

   // in_tready depends only on registered state, never on out_tready
   assign bus.in_tready = !rst && (state != ST_ACK);
   assign bus.out_tid   = HWR_LOCK_ID;

   assign code        = bus.in_tdata[7:0];
   assign lock_id     = bus.in_tdata[8 +: LOCK_ID_BITS];
   assign idx         = lock_id[IDX_BITS-1:0];
   assign id_ok       = 32'(lock_id) < NUM_LOCKS;
   assign unused_bits = ^bus.in_tdata[63:8+LOCK_ID_BITS];

   assign cmd_lock      = (code == CMD_LOCK);
   assign cmd_unlock    = (code == CMD_UNLOCK);
   assign hs_idle       = (state == ST_IDLE) && bus.in_tvalid && bus.in_tready;
   assign hs_drain_last = (state == ST_DRAIN) && bus.in_tvalid && bus.in_tready && bus.in_tlast;

   assign grant      = hs_idle && cmd_lock && id_ok && !locks_held[idx];
   assign release_ok = hs_idle && cmd_unlock && id_ok && locks_held[idx]
                       && (owner[idx] == bus.in_tid);

   always_comb begin
      err_set    = 2'b00;
      err_set[0] = hs_idle && cmd_unlock && !release_ok;
      err_set[1] = hs_idle && (((cmd_lock || cmd_unlock) && !id_ok) || !(cmd_lock || cmd_unlock));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sticky <= 2'b00;
      end else begin
         err_sticky <= (err_clear ? 2'b00 : err_sticky) | err_set;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locks_held <= '0;
         for (int i = 0; i < NUM_LOCKS; i++) begin
            owner[i] <= '0;
         end
      end else if (grant) begin
         locks_held[idx] <= 1'b1;
         owner[idx]      <= bus.in_tid;
      end else if (release_ok) begin
         locks_held[idx] <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         is_lock_q      <= 1'b0;
         bus.out_tvalid <= 1'b0;
         bus.out_tdata  <= '0;
         bus.out_tdest  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hs_idle) begin
                  is_lock_q <= cmd_lock;
                  if (cmd_lock) begin
                     bus.out_tdest <= bus.in_tid;
                     bus.out_tdata <= grant ? ACK_OK : ACK_REJECT;
                  end
                  if (!bus.in_tlast) begin
                     state <= ST_DRAIN;
                  end else if (cmd_lock) begin
                     state          <= ST_ACK;
                     bus.out_tvalid <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               // trailing words carry nothing we use; only the tlast beat matters
               if (hs_drain_last) begin
                  if (is_lock_q) begin
                     state          <= ST_ACK;
                     bus.out_tvalid <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_ACK: begin
               if (bus.out_tready) begin
                  state          <= ST_IDLE;
                  bus.out_tvalid <= 1'b0;
               end
            end
            default: begin
               state          <= ST_IDLE;
               bus.out_tvalid <= 1'b0;
            end
         endcase
      end
   end
endmodule
